// File: rtl/dmemory_sized.sv
// ============================================================================
// dmemory_sized
// ----------------------------------------------------------------------------
// Data memory for the CPU memory stage. Supports byte, half-word and word
// accesses with sign or zero extension on loads, a req/ready handshake with a
// configurable number of wait states, and flagging of misaligned accesses.
//
// Parameters
//   ADDR_BITS    word-address width, memory holds 2**ADDR_BITS 32-bit words
//   WAIT_STATES  extra cycles between accept and response (0..15)
//
// Ports
//   clock_i        system clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   req_i          access request, only sampled while idle
//   mem_write_i    1 = store, 0 = load (sampled with req_i)
//   size_i         00 byte, 01 half, 10 word, 11 reserved (always misaligned)
//   is_unsigned_i  1 = zero-extend loads, 0 = sign-extend loads
//   address_i      byte address; [ADDR_BITS+1:2] word, [1:0] lane
//   write_data_i   right-aligned store data
//   read_data_o    extended load result, valid while ready_o is high
//   ready_o        one-cycle pulse when the access completes
//   misalign_o     one-cycle pulse together with ready_o on a rejected access
//   busy_o         high from the cycle after accept until ready_o falls
// ============================================================================
module dmemory_sized #(
    parameter int ADDR_BITS   = 14,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        mem_write_i,
    input  logic [1:0]  size_i,
    input  logic        is_unsigned_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o,
    output logic        misalign_o,
    output logic        busy_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    // First value loaded into the wait counter; only meaningful when WAIT_STATES > 0.
    localparam logic [3:0] CNT_START = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0] waitCnt_q, waitCnt_d;

    logic        ready_q, ready_d;
    logic        misalign_q, misalign_d;
    logic [31:0] readData_q, readData_d;

    // Request captured at accept time.
    logic                 write_q;
    logic [1:0]           size_q;
    logic                 unsigned_q;
    logic [ADDR_BITS+1:0] addr_q;
    logic [31:0]          wdata_q;

    logic [31:0] memArray_q [DEPTH];

    // Address bits above the word index wrap the array and are ignored.
    logic unusedAddrBits;
    assign unusedAddrBits = ^address_i[31:ADDR_BITS+2];

    // Request currently being served. With zero wait states the response is
    // produced on the accepting edge itself, so the live inputs are used while
    // idle and the captured copy afterwards.
    logic                 curWrite;
    logic [1:0]           curSize;
    logic                 curUnsigned;
    logic [ADDR_BITS+1:0] curAddr;
    logic [31:0]          curWdata;

    always_comb begin
        if (state_q == ST_IDLE) begin
            curWrite    = mem_write_i;
            curSize     = size_i;
            curUnsigned = is_unsigned_i;
            curAddr     = address_i[ADDR_BITS+1:0];
            curWdata    = write_data_i;
        end else begin
            curWrite    = write_q;
            curSize     = size_q;
            curUnsigned = unsigned_q;
            curAddr     = addr_q;
            curWdata    = wdata_q;
        end
    end

    logic [ADDR_BITS-1:0] curIdx;
    logic [1:0]           curLane;
    logic [31:0]          memWord;

    assign curIdx  = curAddr[ADDR_BITS+1:2];
    assign curLane = curAddr[1:0];
    assign memWord = memArray_q[curIdx];

    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (curSize)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = curLane[0];
            2'b10:   misaligned = |curLane;
            default: misaligned = 1'b1;
        endcase
    end

    // Load extraction and extension from the addressed word.
    logic [31:0] loadValue;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    always_comb begin
        loadByte  = memWord[8*curLane +: 8];
        loadHalf  = curLane[1] ? memWord[31:16] : memWord[15:0];
        loadValue = memWord;
        case (curSize)
            2'b00:   loadValue = {{24{loadByte[7] & ~curUnsigned}}, loadByte};
            2'b01:   loadValue = {{16{loadHalf[15] & ~curUnsigned}}, loadHalf};
            default: loadValue = memWord;
        endcase
    end

    // Store merge: only the addressed lanes change, the rest keep their value.
    logic [31:0] storeWord;

    always_comb begin
        storeWord = memWord;
        case (curSize)
            2'b00: storeWord[8*curLane +: 8] = curWdata[7:0];
            2'b01: begin
                if (curLane[1]) begin
                    storeWord[31:16] = curWdata[15:0];
                end else begin
                    storeWord[15:0] = curWdata[15:0];
                end
            end
            default: storeWord = curWdata;
        endcase
    end

    // Next-state logic. The response registers are loaded on the edge that
    // enters RESP, so ready/misalign/read_data line up with the RESP cycle.
    logic enterResp;
    logic memWe;

    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        ready_d    = 1'b0;
        misalign_d = 1'b0;
        readData_d = readData_q;
        enterResp  = 1'b0;
        memWe      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d   = ST_WAIT;
                        waitCnt_d = CNT_START;
                    end
                end
            end
            ST_WAIT: begin
                if (waitCnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        enterResp = (state_d == ST_RESP) && (state_q != ST_RESP);

        if (enterResp) begin
            ready_d    = 1'b1;
            misalign_d = misaligned;
            readData_d = (curWrite || misaligned) ? 32'd0 : loadValue;
            memWe      = curWrite && !misaligned;
        end
    end

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            waitCnt_q  <= 4'd0;
            ready_q    <= 1'b0;
            misalign_q <= 1'b0;
            readData_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            ready_q    <= ready_d;
            misalign_q <= misalign_d;
            readData_q <= readData_d;
        end
    end

    // Request capture; requests arriving while busy are simply not captured.
    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
        end else if (state_q == ST_IDLE && req_i) begin
            write_q    <= mem_write_i;
            size_q     <= size_i;
            unsigned_q <= is_unsigned_i;
            addr_q     <= address_i[ADDR_BITS+1:0];
            wdata_q    <= write_data_i;
        end
    end

    // Array contents survive reset; an aborted store never reaches this write
    // because reset forces the FSM back to IDLE before the commit edge.
    always_ff @(posedge clock_i) begin
        if (memWe) begin
            memArray_q[curIdx] <= storeWord;
        end
    end

    assign read_data_o = readData_q;
    assign ready_o     = ready_q;
    assign misalign_o  = misalign_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmemory_sized.sv
// ============================================================================
// tb_dmemory_sized
// ----------------------------------------------------------------------------
// Directed bench for dmemory_sized: word/half/byte stores and loads with hand
// computed results, misaligned accesses, address wrap, requests while busy and
// reset in the middle of a store.
// ============================================================================
module tb_dmemory_sized;

    localparam int TB_ADDR_BITS = 14;
    localparam int TB_WAIT      = 1;
    localparam logic [31:0] WRAP_OFFSET = 32'(4 * (2 ** TB_ADDR_BITS));

    logic        clock;
    logic        rst_n;
    logic        req;
    logic        memWrite;
    logic [1:0]  size;
    logic        isUnsigned;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    logic        misalign;
    logic        busy;

    int testsRun;
    int testsFailed;

    dmemory_sized #(
        .ADDR_BITS  (TB_ADDR_BITS),
        .WAIT_STATES(TB_WAIT)
    ) dut (
        .clock_i      (clock),
        .rst_n_i      (rst_n),
        .req_i        (req),
        .mem_write_i  (memWrite),
        .size_i       (size),
        .is_unsigned_i(isUnsigned),
        .address_i    (address),
        .write_data_i (writeData),
        .read_data_o  (readData),
        .ready_o      (ready),
        .misalign_o   (misalign),
        .busy_o       (busy)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Runs one access: req for one edge, waits (bounded) for ready, checks the
    // handshake shape and returns the response and edge count to ready.
    task automatic applyStimulus(
        input  logic        wr,
        input  logic [1:0]  sz,
        input  logic        uns,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        output logic [31:0] rd,
        output logic        mis,
        output int          lat
    );
        @(negedge clock);
        req        = 1'b1;
        memWrite   = wr;
        size       = sz;
        isUnsigned = uns;
        address    = addr;
        writeData  = wd;
        @(posedge clock);
        lat = 1;
        #1;
        req = 1'b0;
        checkOutput("busyAfterAccept", 32'(busy), 32'd1);
        while (!ready && lat < 20) begin
            @(posedge clock);
            lat++;
            #1;
        end
        if (!ready) begin
            checkOutput("readyTimeout", 32'(ready), 32'd1);
        end
        rd  = readData;
        mis = misalign;
        @(posedge clock);
        #1;
        checkOutput("readyPulseEnd", 32'(ready), 32'd0);
        checkOutput("busyAfterReady", 32'(busy), 32'd0);
    endtask

    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          pulses;

    // Shorthand: access then check response data and misalign flag.
    task automatic access(
        input string       tag,
        input logic        wr,
        input logic [1:0]  sz,
        input logic        uns,
        input logic [31:0] addr,
        input logic [31:0] wd,
        input logic [31:0] expData,
        input logic        expMis
    );
        logic [31:0] r;
        logic        m;
        int          l;
        applyStimulus(wr, sz, uns, addr, wd, r, m, l);
        checkOutput({tag, "_data"}, r, expData);
        checkOutput({tag, "_mis"}, 32'(m), 32'(expMis));
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        req         = 1'b0;
        memWrite    = 1'b0;
        size        = 2'b10;
        isUnsigned  = 1'b0;
        address     = 32'd0;
        writeData   = 32'd0;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("rstReady", 32'(ready), 32'd0);
        checkOutput("rstMisalign", 32'(misalign), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstReadData", readData, 32'd0);
        @(negedge clock);
        rst_n = 1'b1;

        // Word store then load, with latency check on the load.
        access("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8765_4321, 32'd0, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, mis, lat);
        checkOutput("lw10", rd, 32'h8765_4321);
        checkOutput("lw10Latency", 32'(lat), 32'(TB_WAIT + 1));

        // Byte store into lane 1 and loads back.
        access("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA, 32'd0, 1'b0);
        access("lbu11", 1'b0, 2'b00, 1'b1, 32'h11, 32'd0, 32'h0000_00AA, 1'b0);
        access("lb11", 1'b0, 2'b00, 1'b0, 32'h11, 32'd0, 32'hFFFF_FFAA, 1'b0);
        access("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h8765_AA21, 1'b0);

        // Half store into the upper half.
        access("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, 32'd0, 1'b0);
        access("lh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'hFFFF_8001, 1'b0);
        access("lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 32'h0000_8001, 1'b0);
        access("lw10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h8001_AA21, 1'b0);

        // Misaligned accesses are rejected and leave memory alone.
        access("lw13", 1'b0, 2'b10, 1'b0, 32'h13, 32'd0, 32'd0, 1'b1);
        access("sh11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_5555, 32'd0, 1'b1);
        access("sz11", 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'd0, 1'b1);
        access("lw10d", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h8001_AA21, 1'b0);

        // Address wrap onto word 4, then lanes of the wrapped word.
        access("swWrap", 1'b1, 2'b10, 1'b0, WRAP_OFFSET + 32'h10, 32'h1234_5678, 32'd0, 1'b0);
        access("lwWrap", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h1234_5678, 1'b0);
        access("lb10", 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'h0000_0078, 1'b0);
        access("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 32'h0000_0012, 1'b0);
        access("lh10", 1'b0, 2'b01, 1'b0, 32'h10, 32'd0, 32'h0000_5678, 1'b0);

        // Holding req while busy must not start a second access.
        @(negedge clock);
        req        = 1'b1;
        memWrite   = 1'b0;
        size       = 2'b10;
        isUnsigned = 1'b0;
        address    = 32'h10;
        pulses     = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (ready) pulses++;
            if (i == 2) req = 1'b0;
        end
        checkOutput("busyReqPulses", 32'(pulses), 32'd1);

        // Reset during the wait state of a store drops the store.
        access("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 32'd0, 1'b0);
        @(negedge clock);
        req        = 1'b1;
        memWrite   = 1'b1;
        size       = 2'b10;
        isUnsigned = 1'b0;
        address    = 32'h20;
        writeData  = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        req = 1'b0;
        checkOutput("abortBusyBefore", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abortBusyLow", 32'(busy), 32'd0);
        pulses = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (ready) pulses++;
        end
        @(negedge clock);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (ready) pulses++;
        end
        checkOutput("abortNoReady", 32'(pulses), 32'd0);
        access("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h1122_3344, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
